// File: rtl/ddr3_amm_pkg.sv
// Shared types for the DDR3 Avalon-MM port arbiter: FSM states and the read tag
// that steers returning read beats back to the issuing master.
package ddr3_amm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_BURST
  } state_t;

  // Tag fields are sized for the largest supported build (8 ports, 16-bit burstcount).
  localparam int TAG_PORT_W  = 3;
  localparam int TAG_BURST_W = 16;

  typedef struct packed {
    logic [TAG_PORT_W-1:0]  port;
    logic [TAG_BURST_W-1:0] burstcount;
  } rd_tag_t;

endpackage

// File: rtl/ddr3_amm_tag_fifo.sv
// Synchronous FIFO of read tags with registered full/empty flags and occupancy.
// A pop in the same cycle frees a slot that a push in that cycle may use.
module ddr3_amm_tag_fifo
  import ddr3_amm_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rd_tag_t          push_data,
  input  logic             pop,
  output rd_tag_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  rd_tag_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  logic [CNT_W-1:0] count_nxt;

  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ddr3_amm_port_arbiter.sv
// N-port Avalon-MM front-end for the EMIF controller port: round-robin command
// arbitration with write-burst grant lock and tag-steered read data return.
module ddr3_amm_port_arbiter
  import ddr3_amm_pkg::*;
#(
  parameter int  NUM_PORTS     = 4,
  parameter int  DATA_W        = 256,
  parameter int  ADDR_W        = 25,
  parameter int  BURST_W       = 7,
  parameter int  RD_FIFO_DEPTH = 16,
  localparam int BE_W   = DATA_W / 8,
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W  = $clog2(RD_FIFO_DEPTH) + 1
) (
  input  logic                        emif_usr_clk,
  input  logic                        emif_usr_reset,
  input  logic [NUM_PORTS-1:0]        s_read,
  input  logic [NUM_PORTS-1:0]        s_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_address,
  input  logic [NUM_PORTS*DATA_W-1:0] s_writedata,
  input  logic [NUM_PORTS*BE_W-1:0]   s_byteenable,
  input  logic [NUM_PORTS*BURST_W-1:0] s_burstcount,
  output logic [NUM_PORTS-1:0]        s_ready,
  output logic [DATA_W-1:0]           s_readdata,
  output logic [NUM_PORTS-1:0]        s_readdatavalid,
  input  logic                        amm_ready,
  output logic                        amm_read,
  output logic                        amm_write,
  output logic [ADDR_W-1:0]           amm_address,
  output logic [DATA_W-1:0]           amm_writedata,
  output logic [BE_W-1:0]             amm_byteenable,
  output logic [BURST_W-1:0]          amm_burstcount,
  input  logic [DATA_W-1:0]           amm_readdata,
  input  logic                        amm_readdatavalid,
  output logic [CNT_W-1:0]            rd_outstanding,
  output logic                        err_burst0,
  output logic                        err_orphan_rd
);

  state_t             state;
  logic [PORT_W-1:0]  winner, rr_ptr;
  logic [BURST_W-1:0] wr_beats, rd_beats;
  logic               w_read, w_write, room, grant_ok, cmd_accept;
  logic [BURST_W-1:0] w_bc, bc_eff;
  logic               tag_full, tag_empty, rd_beat, rd_last;
  rd_tag_t            head, push_tag;

  function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [PORT_W-1:0]    ptr);
    logic [PORT_W-1:0] pick;
    logic              found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_PORTS]) begin
        pick  = PORT_W'((int'(ptr) + i) % NUM_PORTS);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (int'(p) == NUM_PORTS - 1) ? '0 : p + PORT_W'(1);
  endfunction

  assign w_read  = s_read[winner];
  assign w_write = s_write[winner];
  assign w_bc    = s_burstcount[int'(winner)*BURST_W +: BURST_W];
  assign bc_eff  = (w_bc == '0) ? BURST_W'(1) : w_bc;

  assign amm_address    = s_address[int'(winner)*ADDR_W +: ADDR_W];
  assign amm_writedata  = s_writedata[int'(winner)*DATA_W +: DATA_W];
  assign amm_byteenable = s_byteenable[int'(winner)*BE_W +: BE_W];
  assign amm_burstcount = bc_eff;

  // A beat that completes the head burst frees its tag slot in the same cycle.
  assign rd_beat = amm_readdatavalid & ~tag_empty;
  assign rd_last = rd_beat & ((TAG_BURST_W'(rd_beats) + TAG_BURST_W'(1)) == head.burstcount);
  assign room    = ~tag_full | rd_last;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    amm_read        = 1'b0;
    amm_write       = 1'b0;
    grant_ok        = 1'b0;
    s_ready         = '0;
    s_readdatavalid = '0;
    if (state == CMD) begin
      amm_read  = w_read & room;
      amm_write = w_write & ~w_read;
      grant_ok  = w_read ? room : 1'b1;
    end else if (state == WR_BURST) begin
      amm_write = w_write;
      grant_ok  = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_ready[i]         = grant_ok & amm_ready & (int'(winner) == i);
      s_readdatavalid[i] = rd_beat & (int'(head.port) == i);
    end
  end

  assign cmd_accept = (state == CMD) & amm_ready & (amm_read | amm_write);
  assign s_readdata = amm_readdata;
  assign push_tag   = '{port: TAG_PORT_W'(winner), burstcount: TAG_BURST_W'(bc_eff)};

  always_ff @(posedge emif_usr_clk or posedge emif_usr_reset) begin
    if (emif_usr_reset) begin
      state      <= IDLE;
      winner     <= '0;
      rr_ptr     <= '0;
      wr_beats   <= '0;
      err_burst0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(s_read | s_write)) begin
            winner <= rr_pick(s_read | s_write, rr_ptr);
            state  <= CMD;
          end
        end
        CMD: begin
          if (!(w_read | w_write)) begin
            state <= IDLE;
          end else if (cmd_accept) begin
            if (w_bc == '0) err_burst0 <= 1'b1;
            if (amm_read || bc_eff == BURST_W'(1)) begin
              rr_ptr <= next_port(winner);
              state  <= IDLE;
            end else begin
              wr_beats <= bc_eff - BURST_W'(1);
              state    <= WR_BURST;
            end
          end
        end
        WR_BURST: begin
          if (amm_write && amm_ready) begin
            wr_beats <= wr_beats - BURST_W'(1);
            if (wr_beats == BURST_W'(1)) begin
              rr_ptr <= next_port(winner);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge emif_usr_clk or posedge emif_usr_reset) begin
    if (emif_usr_reset) begin
      rd_beats      <= '0;
      err_orphan_rd <= 1'b0;
    end else begin
      if (rd_last)      rd_beats <= '0;
      else if (rd_beat) rd_beats <= rd_beats + BURST_W'(1);
      if (amm_readdatavalid && tag_empty) err_orphan_rd <= 1'b1;
    end
  end

  ddr3_amm_tag_fifo #(.DEPTH(RD_FIFO_DEPTH)) u_tag_fifo (
    .clk       (emif_usr_clk),
    .rst       (emif_usr_reset),
    .push      (amm_read & amm_ready),
    .push_data (push_tag),
    .pop       (rd_last),
    .head      (head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (rd_outstanding)
  );

endmodule

// File: tb/tb_ddr3_amm_port_arbiter.sv
// Randomized bench for ddr3_amm_port_arbiter: a transaction-level model of the
// masters, arbitration rules and read tag ordering predicts every DUT output.
module tb_ddr3_amm_port_arbiter;

  localparam int N = 4, DW = 32, BEW = DW / 8, AW = 25, BW = 7, DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      s_read, s_write, s_ready, s_readdatavalid;
  logic [N*AW-1:0]   s_address;
  logic [N*DW-1:0]   s_writedata;
  logic [N*BEW-1:0]  s_byteenable;
  logic [N*BW-1:0]   s_burstcount;
  logic [DW-1:0]     s_readdata, amm_writedata, amm_readdata;
  logic              amm_ready, amm_read, amm_write, amm_readdatavalid;
  logic [AW-1:0]     amm_address;
  logic [BEW-1:0]    amm_byteenable;
  logic [BW-1:0]     amm_burstcount;
  logic [CW-1:0]     rd_outstanding;
  logic              err_burst0, err_orphan_rd;

  always #5 clk = ~clk;

  ddr3_amm_port_arbiter #(
    .NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .emif_usr_clk(clk), .emif_usr_reset(rst),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
    .s_ready(s_ready), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .amm_ready(amm_ready), .amm_read(amm_read), .amm_write(amm_write),
    .amm_address(amm_address), .amm_writedata(amm_writedata),
    .amm_byteenable(amm_byteenable), .amm_burstcount(amm_burstcount),
    .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
    .rd_outstanding(rd_outstanding), .err_burst0(err_burst0), .err_orphan_rd(err_orphan_rd)
  );

  // Master transaction state (one outstanding request per port).
  bit             m_pend[N], m_rd[N], m_new_beat[N];
  int             m_bc[N];
  logic [AW-1:0]  m_addr[N];
  logic [DW-1:0]  m_wdata[N];
  logic [BEW-1:0] m_be[N];

  // Reference model: outstanding read bursts in issue order, plus grant bookkeeping.
  typedef struct { int port; int beats; } tag_t;
  tag_t tags[$];
  int   rd_cnt, grant = -1, beats_left, rr, emif_pend;
  bit   e_b0, e_orph;
  bit   quiet, rd_only, hold_rd, force_orphan;
  int   n_cmp, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " s_ready"}, 64'(s_ready), 64'(0));
    check({tag, " s_readdatavalid"}, 64'(s_readdatavalid), 64'(0));
    check({tag, " amm_read"}, 64'(amm_read), 64'(0));
    check({tag, " amm_write"}, 64'(amm_write), 64'(0));
    check({tag, " rd_outstanding"}, 64'(rd_outstanding), 64'(0));
    check({tag, " err_burst0"}, 64'(err_burst0), 64'(0));
    check({tag, " err_orphan_rd"}, 64'(err_orphan_rd), 64'(0));
  endtask

  function automatic int pick(input bit req[N], input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit drained();
    bit busy = 0;
    for (int p = 0; p < N; p++) busy |= m_pend[p];
    return !busy && grant < 0 && tags.size() == 0 && emif_pend == 0;
  endfunction

  task automatic finish_txn(input int w);
    m_pend[w] = 0;
    rr        = (w + 1) % N;
    grant     = -1;
  endtask

  task automatic reset_model();
    grant = -1; beats_left = 0; rr = 0; rd_cnt = 0; emif_pend = 0;
    e_b0 = 0; e_orph = 0;
    tags.delete();
  endtask

  // Stimulus: masters and EMIF slave, driven on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < N; p++) m_pend[p] = 0;
      amm_ready = 1'b0;
      amm_readdatavalid = 1'b0;
    end else begin
      for (int p = 0; p < N; p++) begin
        if (!m_pend[p] && !quiet && $urandom_range(0, 3) == 0) begin
          m_pend[p]     = 1;
          m_rd[p]       = rd_only ? 1'b1 : 1'($urandom_range(0, 1));
          m_bc[p]       = int'($urandom_range(0, 8));
          m_addr[p]     = AW'($urandom);
          m_new_beat[p] = 1;
        end
        if (m_new_beat[p]) begin
          m_wdata[p]    = DW'($urandom);
          m_be[p]       = BEW'($urandom);
          m_new_beat[p] = 0;
        end
      end
      amm_ready    = ($urandom_range(0, 3) != 0);
      amm_readdata = DW'($urandom);
      if (force_orphan) begin
        amm_readdatavalid = 1'b1;
        force_orphan      = 0;
      end else if (!hold_rd && emif_pend > 0 && $urandom_range(0, 2) != 0) begin
        amm_readdatavalid = 1'b1;
        emif_pend--;
      end else begin
        amm_readdatavalid = 1'b0;
      end
    end
    for (int p = 0; p < N; p++) begin
      s_read[p]                  = m_pend[p] && m_rd[p];
      s_write[p]                 = m_pend[p] && !m_rd[p];
      s_address[p*AW +: AW]      = m_addr[p];
      s_writedata[p*DW +: DW]    = m_wdata[p];
      s_byteenable[p*BEW +: BEW] = m_be[p];
      s_burstcount[p*BW +: BW]   = BW'(m_bc[p]);
    end
  end

  // Monitor / scoreboard: samples mid-cycle, compares, then advances the model
  // to the state it predicts for the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (rst) check_zero_outputs("reset");
    else model_step();
  end

  task automatic model_step();
    logic [N-1:0] e_ready, e_rdv;
    bit           req[N];
    bit           e_rd, e_wr, acc;
    int           w, eff;
    tag_t         t;
    e_ready = '0; e_rdv = '0; e_rd = 0; e_wr = 0; acc = 0;

    check("rd_outstanding", 64'(rd_outstanding), 64'(tags.size()));
    check("err_burst0", 64'(err_burst0), 64'(e_b0));
    check("err_orphan_rd", 64'(err_orphan_rd), 64'(e_orph));

    if (amm_readdatavalid) begin
      if (tags.size() == 0) begin
        e_orph = 1;
      end else begin
        e_rdv[tags[0].port] = 1'b1;
        rd_cnt++;
        if (rd_cnt == tags[0].beats) begin
          void'(tags.pop_front());
          rd_cnt = 0;
        end
      end
      check("s_readdata", 64'(s_readdata), 64'(amm_readdata));
    end
    check("s_readdatavalid", 64'(s_readdatavalid), 64'(e_rdv));

    for (int p = 0; p < N; p++) req[p] = m_pend[p];
    if (grant < 0) begin
      // Arbitration bubble: the winner is chosen now and served next cycle.
      w = pick(req, rr);
      if (w >= 0) begin
        grant      = w;
        beats_left = 0;
      end
    end else begin
      w   = grant;
      eff = (m_bc[w] == 0) ? 1 : m_bc[w];
      if (beats_left == 0 && m_rd[w]) begin
        e_rd       = (tags.size() < DEPTH);
        e_ready[w] = amm_ready && e_rd;
      end else begin
        e_wr       = 1;
        e_ready[w] = amm_ready;
      end
      acc = e_ready[w];
      if (e_rd || e_wr) begin
        check("amm_address", 64'(amm_address), 64'(m_addr[w]));
        check("amm_burstcount", 64'(amm_burstcount), 64'(eff));
      end
      if (e_wr) begin
        check("amm_writedata", 64'(amm_writedata), 64'(m_wdata[w]));
        check("amm_byteenable", 64'(amm_byteenable), 64'(m_be[w]));
      end
      if (acc) begin
        if (beats_left == 0) begin
          if (m_bc[w] == 0) e_b0 = 1;
          if (m_rd[w]) begin
            t.port  = w;
            t.beats = eff;
            tags.push_back(t);
            emif_pend += eff;
            finish_txn(w);
          end else if (eff == 1) begin
            finish_txn(w);
          end else begin
            beats_left    = eff - 1;
            m_new_beat[w] = 1;
          end
        end else begin
          beats_left--;
          if (beats_left == 0) finish_txn(w);
          else m_new_beat[w] = 1;
        end
      end
    end
    check("s_ready", 64'(s_ready), 64'(e_ready));
    check("amm_read", 64'(amm_read), 64'(e_rd));
    check("amm_write", 64'(amm_write), 64'(e_wr));
  endtask

  task automatic wait_drained(input string name);
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      #2;
      ok = drained();
    end
    check(name, 64'(ok), 64'(1));
  endtask

  initial begin
    s_read = '0; s_write = '0; s_address = '0; s_writedata = '0;
    s_byteenable = '0; s_burstcount = '0;
    amm_ready = 1'b0; amm_readdata = '0; amm_readdatavalid = 1'b0;
    for (int p = 0; p < N; p++) begin
      m_pend[p] = 0; m_rd[p] = 0; m_new_beat[p] = 0; m_bc[p] = 1;
      m_addr[p] = '0; m_wdata[p] = '0; m_be[p] = '0;
    end
    reset_model();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Mixed random traffic.
    repeat (3000) @(negedge clk);

    // Fill the tag FIFO with returns withheld, so further reads must stall.
    begin
      bit full_seen = 0;
      rd_only = 1;
      hold_rd = 1;
      for (int i = 0; i < 3000 && !full_seen; i++) begin
        @(negedge clk);
        #2;
        full_seen = (tags.size() == DEPTH);
      end
      check("fifo_fill_timeout", 64'(full_seen), 64'(1));
      repeat (20) @(negedge clk);
      hold_rd = 0;
      rd_only = 0;
    end

    // Orphan read beat with nothing outstanding.
    quiet = 1;
    wait_drained("drain_before_orphan");
    force_orphan = 1;
    repeat (4) @(negedge clk);
    quiet = 0;

    // Reset asserted in the middle of a write burst.
    begin
      bit in_burst = 0;
      for (int i = 0; i < 5000 && !in_burst; i++) begin
        @(negedge clk);
        #2;
        in_burst = (grant >= 0 && beats_left > 0);
      end
      check("burst_wait_timeout", 64'(in_burst), 64'(1));
      rst = 1'b1;
      #1;
      check_zero_outputs("async_reset");
      reset_model();
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
    end

    repeat (2000) @(negedge clk);
    quiet = 1;
    wait_drained("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
